nonce_dispatcher: RTL and testbench
===================================

// Module: nonce_dispatcher
// PURPOSE
//  Schedules NUM_CORES SHA solve cores over one work unit (midstate + header).
//  Splits the 32-bit nonce space into equal ranges and pulses load to all cores.
//  Runs the search, round-robin arbitrates core solutions, and presents one golden nonce at a time
//  on the sol_claim/sol_response handshake. Reports exhaustion when every range is searched clean.
// PARAMETERS
//  NUM_CORES  4   number of SHA cores; power of two, 1..16
//  CNT_W      16  width of the solution counter (saturating)
// PORTS
//  clk          in   1            system clock, rising edge
//  n_rst        in   1            asynchronous active-low reset
//  work_valid   in   1            new midstate/header is stable in the core shift registers
//  work_ready   out  1            dispatcher in IDLE; accepts work_valid
//  abort        in   1            stop search, return to IDLE
//  core_load    out  NUM_CORES    1-cycle pulse: core latches state and base nonce
//  core_solve   out  NUM_CORES    level: core searches while high
//  core_base    out  32*NUM_CORES start nonce of core i = i << (32-log2(NUM_CORES))
//  core_found   in   NUM_CORES    level: core i holds a golden nonce until acked
//  core_nonce   in   32*NUM_CORES golden nonce of core i, valid while core_found[i]
//  core_done    in   NUM_CORES    1-cycle pulse: core i finished its range
//  core_ack     out  NUM_CORES    1-cycle pulse: core i found consumed
//  sol_claim    out  1            golden nonce presented on sol_nonce
//  sol_nonce    out  32           presented golden nonce
//  sol_response in   1            host took the claim
//  exhausted    out  1            1-cycle pulse: all ranges done, no pending solutions
//  sol_count    out  CNT_W        solutions claimed for this work unit
// BEHAVIOUR
//  Reset: state IDLE; work_ready=1; every other output 0, including sol_nonce, sol_count, done_mask and rr_ptr.
//  core_base is a constant per core and is not reset.
//  All outputs are registered.
//  States: IDLE, LOAD, SOLVE, CLAIM, DONE.
//  IDLE:  work_ready=1. work_valid -> LOAD. Clears done_mask, sol_count and rr_ptr.
//  LOAD:  exactly 1 cycle; core_load = all ones; -> SOLVE.
//  SOLVE: core_solve[i] = ~done_mask[i]. A core_done[i] pulse sets done_mask[i].
//         Any core_found -> CLAIM. Winner is the first set bit at or above rr_ptr, wrapping modulo NUM_CORES.
//         On that transition edge: latch sol_nonce = core_nonce[winner] and pulse core_ack[winner] for 1 cycle.
//         Also set sol_claim=1, rr_ptr = winner+1 (mod N), and saturating-increment sol_count.
//         Else if done_mask is all ones -> DONE.
//  CLAIM: sol_claim=1; sol_nonce held stable; core_solve all 0; core_done still recorded.
//         sol_response -> SOLVE (sol_claim=0 next cycle). sol_response outside CLAIM is ignored.
//  DONE:  exhausted=1 for 1 cycle -> IDLE.
//  Latency: core_found sampled in SOLVE at edge N -> sol_claim/core_ack high from N to N+1.
//  Simultaneous finds: one per claim, round-robin. The others stay pending (level) and are served after sol_response.
//  found and done on the same core, same cycle: found is claimed; the done bit is still set.
//  Last core_done together with any core_found: CLAIM first; DONE only after all founds are served.
//  abort (any state, highest priority): next cycle state IDLE.
//  On that cycle sol_claim, core_solve, core_load and core_ack are 0; sol_nonce is held; no exhausted pulse.
//  work_valid outside IDLE is ignored.
//  sol_count saturates at 2^CNT_W-1.
//  n_rst low mid-operation: immediate return to reset values.
// TESTING
//  T1 reset, work_valid 1 cycle -> core_load=4'b1111 for exactly 1 cycle.
//     Bases 0x00000000/0x40000000/0x80000000/0xC0000000; core_solve=4'b1111.
//  T2 core_found[2], nonce 0x1234ABCD -> next cycle sol_claim=1, sol_nonce=0x1234ABCD, core_ack=4'b0100, core_solve=0.
//     sol_response -> SOLVE, sol_count=1.
//  T3 core_found=4'b1011 held, rr_ptr=0 -> claims served in order core0, core1, core3, one per sol_response; sol_count=3.
//  T4 core_done pulses on cores 0..3 at different cycles -> core_solve bits drop individually.
//     After the last pulse: exhausted pulse, then work_ready=1.
//  T5 abort while in CLAIM -> next cycle sol_claim=0, work_ready=1; later sol_response has no effect.
//  T6 core_done[3] and core_found[3] in the same cycle as the last done -> CLAIM first.
//     After sol_response: DONE, exhausted pulse.

Source files
------------

// File: rtl/nonce_dispatcher_if.sv
// nonce_dispatcher_if: work, core and solution signals shared by the dispatcher and its environment
// Ports (master = dispatcher side):
//   work_valid/work_ready/abort      work unit handshake and search abort
//   core_load/solve/base/ack         dispatcher -> cores control, range bases, found acknowledge
//   core_found/nonce/done            cores -> dispatcher golden nonce and range completion
//   sol_claim/nonce/response         golden nonce presentation handshake to the host
//   exhausted/sol_count              end-of-search pulse and per-work-unit solution count
interface nonce_dispatcher_if #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 16
);
    logic                      work_valid;
    logic                      work_ready;
    logic                      abort;
    logic [NUM_CORES-1:0]      core_load;
    logic [NUM_CORES-1:0]      core_solve;
    logic [32*NUM_CORES-1:0]   core_base;
    logic [NUM_CORES-1:0]      core_found;
    logic [32*NUM_CORES-1:0]   core_nonce;
    logic [NUM_CORES-1:0]      core_done;
    logic [NUM_CORES-1:0]      core_ack;
    logic                      sol_claim;
    logic [31:0]               sol_nonce;
    logic                      sol_response;
    logic                      exhausted;
    logic [CNT_W-1:0]          sol_count;
    modport master (
        input  work_valid, abort, core_found, core_nonce, core_done, sol_response,
        output work_ready, core_load, core_solve, core_base, core_ack,
               sol_claim, sol_nonce, exhausted, sol_count
    );
    modport slave (
        output work_valid, abort, core_found, core_nonce, core_done, sol_response,
        input  work_ready, core_load, core_solve, core_base, core_ack,
               sol_claim, sol_nonce, exhausted, sol_count
    );
endinterface

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: splits the nonce space over NUM_CORES cores, arbitrates their solutions, reports exhaustion
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    nonce_dispatcher_if.master: work handshake, core control/status, solution handshake
module nonce_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 16
) (
    input logic                clk,
    input logic                n_rst,
    nonce_dispatcher_if.master bus
);
    localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam int SH = 32 - $clog2(NUM_CORES);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SOLVE = 3'd2;
    localparam logic [2:0] CLAIM = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]           state, nxt;
    logic [NUM_CORES-1:0] done_mask, done_nxt, ack_nxt;
    logic [NUM_CORES-1:0] core_load, core_solve, core_ack;
    logic [PW-1:0]        rr_ptr, win;
    logic                 hit, grab;
    logic [31:0]          win_nonce, sol_nonce;
    logic                 sol_claim, work_ready, exhausted;
    logic [CNT_W-1:0]     sol_count;

    // Round-robin pick: first found at or above rr_ptr, then wrap to the low cores.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int j = 0; j < NUM_CORES; j++)
            if (!hit && j >= int'(rr_ptr) && bus.core_found[j]) begin
                hit = 1'b1;
                win = PW'(j);
            end
        for (int j = 0; j < NUM_CORES; j++)
            if (!hit && j < int'(rr_ptr) && bus.core_found[j]) begin
                hit = 1'b1;
                win = PW'(j);
            end
    end

    always_comb begin
        win_nonce = '0;
        ack_nxt   = '0;
        for (int j = 0; j < NUM_CORES; j++)
            if (int'(win) == j) begin
                win_nonce  = bus.core_nonce[j*32 +: 32];
                ack_nxt[j] = grab;
            end
    end

    // Done pulses count while searching or waiting on the host; the exhaustion
    // test sees this cycle's pulses so the last done needs no extra cycle.
    assign done_nxt = (state == SOLVE || state == CLAIM) ? done_mask | bus.core_done : done_mask;

    // Abort wins everywhere; pending finds are always served before exhaustion.
    assign nxt = bus.abort     ? IDLE :
                 state == IDLE  ? (bus.work_valid ? LOAD : IDLE) :
                 state == LOAD  ? SOLVE :
                 state == SOLVE ? (hit ? CLAIM : &done_nxt ? DONE : SOLVE) :
                 state == CLAIM ? (bus.sol_response ? SOLVE : CLAIM) :
                 IDLE;

    assign grab = state == SOLVE && nxt == CLAIM;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            done_mask  <= '0;
            rr_ptr     <= '0;
            sol_count  <= '0;
            sol_nonce  <= '0;
            core_ack   <= '0;
            core_load  <= '0;
            core_solve <= '0;
            sol_claim  <= 1'b0;
            work_ready <= 1'b1;
            exhausted  <= 1'b0;
        end else begin
            state      <= nxt;
            done_mask  <= state == IDLE ? '0 : done_nxt;
            rr_ptr     <= state == IDLE ? '0 : grab ? PW'((int'(win) + 1) % NUM_CORES) : rr_ptr;
            sol_count  <= state == IDLE ? '0 :
                          (grab && sol_count != '1) ? sol_count + CNT_W'(1) : sol_count;
            sol_nonce  <= grab ? win_nonce : sol_nonce;
            core_ack   <= ack_nxt;
            core_load  <= nxt == LOAD ? '1 : '0;
            core_solve <= nxt == SOLVE ? ~done_nxt : '0;
            sol_claim  <= nxt == CLAIM;
            work_ready <= nxt == IDLE;
            exhausted  <= nxt == DONE;
        end
    end

    // Core i starts at the bottom of the i-th equal slice of the nonce space.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_base
        assign bus.core_base[i*32 +: 32] = 32'(64'(i) << SH);
    end

    assign bus.work_ready = work_ready;
    assign bus.core_load  = core_load;
    assign bus.core_solve = core_solve;
    assign bus.core_ack   = core_ack;
    assign bus.sol_claim  = sol_claim;
    assign bus.sol_nonce  = sol_nonce;
    assign bus.exhausted  = exhausted;
    assign bus.sol_count  = sol_count;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb_nonce_dispatcher: directed vector table plus hand sequences for multi-cycle corners
module tb_nonce_dispatcher;
    localparam logic [31:0] N0 = 32'h0000_1111;
    localparam logic [31:0] N1 = 32'h4000_2222;
    localparam logic [31:0] N2 = 32'h1234_ABCD;
    localparam logic [31:0] N3 = 32'hC000_3333;

    typedef struct {
        logic       wv;
        logic       ab;
        logic [3:0] fnd;
        logic [3:0] dn;
        logic       rsp;
    } in_t;
    typedef struct {
        logic        wr;
        logic [3:0]  ld;
        logic [3:0]  sv;
        logic [3:0]  ack;
        logic        clm;
        logic [31:0] nonce;
        logic        exh;
        logic [15:0] cnt;
    } exp_t;
    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[14];
    logic [31:0] nonces[4];
    logic [1:0]  order[3];
    logic [3:0]  fnd;

    nonce_dispatcher_if #(.NUM_CORES(4), .CNT_W(16)) bus();
    nonce_dispatcher #(.NUM_CORES(4), .CNT_W(16)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic in_t mi(input logic wv, input logic ab, input logic [3:0] f,
                               input logic [3:0] d, input logic rsp);
        in_t v;
        v.wv = wv; v.ab = ab; v.fnd = f; v.dn = d; v.rsp = rsp;
        return v;
    endfunction

    function automatic exp_t me(input logic wr, input logic [3:0] ld, input logic [3:0] sv,
                                input logic [3:0] ack, input logic clm, input logic [31:0] nonce,
                                input logic exh, input logic [15:0] cnt);
        exp_t e;
        e.wr = wr; e.ld = ld; e.sv = sv; e.ack = ack; e.clm = clm;
        e.nonce = nonce; e.exh = exh; e.cnt = cnt;
        return e;
    endfunction

    task automatic drive(input in_t v);
        bus.work_valid   = v.wv;
        bus.abort        = v.ab;
        bus.core_found   = v.fnd;
        bus.core_done    = v.dn;
        bus.sol_response = v.rsp;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s %s got %h want %h", tag, fld, act, want);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk(tag, "work_ready", 32'(bus.work_ready), 32'(e.wr));
        chk(tag, "core_load",  32'(bus.core_load),  32'(e.ld));
        chk(tag, "core_solve", 32'(bus.core_solve), 32'(e.sv));
        chk(tag, "core_ack",   32'(bus.core_ack),   32'(e.ack));
        chk(tag, "sol_claim",  32'(bus.sol_claim),  32'(e.clm));
        chk(tag, "sol_nonce",  bus.sol_nonce,       e.nonce);
        chk(tag, "exhausted",  32'(bus.exhausted),  32'(e.exh));
        chk(tag, "sol_count",  32'(bus.sol_count),  32'(e.cnt));
    endtask

    initial begin
        nonces[0] = N0; nonces[1] = N1; nonces[2] = N2; nonces[3] = N3;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3;
        bus.core_nonce = {N3, N2, N1, N0};
        // T1/T2/T4 as one continuous run: load, claim core2, then staggered dones to exhaustion
        tbl[0]  = '{mi(1'b1, 1'b0, 4'h0, 4'h0, 1'b0), me(1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0, 16'd0)};
        tbl[1]  = '{mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0), me(1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 32'h0, 1'b0, 16'd0)};
        tbl[2]  = '{mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0), me(1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 32'h0, 1'b0, 16'd0)};
        tbl[3]  = '{mi(1'b0, 1'b0, 4'h4, 4'h0, 1'b0), me(1'b0, 4'h0, 4'h0, 4'h4, 1'b1, N2,    1'b0, 16'd1)};
        tbl[4]  = '{mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0), me(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, N2,    1'b0, 16'd1)};
        tbl[5]  = '{mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b1), me(1'b0, 4'h0, 4'hF, 4'h0, 1'b0, N2,    1'b0, 16'd1)};
        tbl[6]  = '{mi(1'b0, 1'b0, 4'h0, 4'h1, 1'b0), me(1'b0, 4'h0, 4'hE, 4'h0, 1'b0, N2,    1'b0, 16'd1)};
        tbl[7]  = '{mi(1'b1, 1'b0, 4'h0, 4'h0, 1'b0), me(1'b0, 4'h0, 4'hE, 4'h0, 1'b0, N2,    1'b0, 16'd1)};
        tbl[8]  = '{mi(1'b0, 1'b0, 4'h0, 4'h4, 1'b0), me(1'b0, 4'h0, 4'hA, 4'h0, 1'b0, N2,    1'b0, 16'd1)};
        tbl[9]  = '{mi(1'b0, 1'b0, 4'h0, 4'h8, 1'b0), me(1'b0, 4'h0, 4'h2, 4'h0, 1'b0, N2,    1'b0, 16'd1)};
        tbl[10] = '{mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b1), me(1'b0, 4'h0, 4'h2, 4'h0, 1'b0, N2,    1'b0, 16'd1)};
        tbl[11] = '{mi(1'b0, 1'b0, 4'h0, 4'h2, 1'b0), me(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, N2,    1'b1, 16'd1)};
        tbl[12] = '{mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0), me(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, N2,    1'b0, 16'd1)};
        tbl[13] = '{mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0), me(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, N2,    1'b0, 16'd0)};

        drive(mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
        tick;
        tick;
        check_out("reset", me(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0, 16'd0));
        chk("t1", "base0", bus.core_base[31:0],   32'h0000_0000);
        chk("t1", "base1", bus.core_base[63:32],  32'h4000_0000);
        chk("t1", "base2", bus.core_base[95:64],  32'h8000_0000);
        chk("t1", "base3", bus.core_base[127:96], 32'hC000_0000);
        n_rst = 1'b1;

        for (int r = 0; r < 14; r++) begin
            drive(tbl[r].i);
            tick;
            check_out($sformatf("vec%0d", r), tbl[r].e);
        end

        // T3: three simultaneous finds served 0,1,3; each core drops its find once acked
        drive(mi(1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
        tick;
        check_out("t3_load", me(1'b0, 4'hF, 4'h0, 4'h0, 1'b0, N2, 1'b0, 16'd0));
        drive(mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
        tick;
        check_out("t3_solve", me(1'b0, 4'h0, 4'hF, 4'h0, 1'b0, N2, 1'b0, 16'd0));
        fnd = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            drive(mi(1'b0, 1'b0, fnd, 4'h0, 1'b0));
            tick;
            check_out($sformatf("t3_claim%0d", k),
                      me(1'b0, 4'h0, 4'h0, 4'(4'd1 << order[k]), 1'b1, nonces[order[k]], 1'b0, 16'(k + 1)));
            fnd[order[k]] = 1'b0;
            drive(mi(1'b0, 1'b0, fnd, 4'h0, 1'b1));
            tick;
            check_out($sformatf("t3_resp%0d", k),
                      me(1'b0, 4'h0, 4'hF, 4'h0, 1'b0, nonces[order[k]], 1'b0, 16'(k + 1)));
        end

        // T5: abort during CLAIM, then a stray response
        drive(mi(1'b0, 1'b0, 4'h1, 4'h0, 1'b0));
        tick;
        check_out("t5_claim", me(1'b0, 4'h0, 4'h0, 4'h1, 1'b1, N0, 1'b0, 16'd4));
        drive(mi(1'b0, 1'b1, 4'h0, 4'h0, 1'b0));
        tick;
        check_out("t5_abort", me(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, N0, 1'b0, 16'd4));
        drive(mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b1));
        tick;
        check_out("t5_stray", me(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, N0, 1'b0, 16'd0));

        // T6: last done coincides with a find on the same core
        drive(mi(1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
        tick;
        check_out("t6_load", me(1'b0, 4'hF, 4'h0, 4'h0, 1'b0, N0, 1'b0, 16'd0));
        drive(mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
        tick;
        check_out("t6_solve", me(1'b0, 4'h0, 4'hF, 4'h0, 1'b0, N0, 1'b0, 16'd0));
        drive(mi(1'b0, 1'b0, 4'h0, 4'h7, 1'b0));
        tick;
        check_out("t6_done3", me(1'b0, 4'h0, 4'h8, 4'h0, 1'b0, N0, 1'b0, 16'd0));
        drive(mi(1'b0, 1'b0, 4'h8, 4'h8, 1'b0));
        tick;
        check_out("t6_claim", me(1'b0, 4'h0, 4'h0, 4'h8, 1'b1, N3, 1'b0, 16'd1));
        drive(mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b1));
        tick;
        check_out("t6_resp", me(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, N3, 1'b0, 16'd1));
        drive(mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
        tick;
        check_out("t6_exh", me(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, N3, 1'b1, 16'd1));
        tick;
        check_out("t6_idle", me(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, N3, 1'b0, 16'd1));

        // Reset asserted mid-claim returns to reset values without a clock edge
        drive(mi(1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
        tick;
        drive(mi(1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
        tick;
        drive(mi(1'b0, 1'b0, 4'h4, 4'h0, 1'b0));
        tick;
        check_out("t7_claim", me(1'b0, 4'h0, 4'h0, 4'h4, 1'b1, N2, 1'b0, 16'd1));
        #2 n_rst = 1'b0;
        #1;
        check_out("t7_reset", me(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0, 16'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
